// File: rtl/line_beat_serializer.sv
// line_beat_serializer
//   Captures one cache line from the L2 way-select mux and returns it toward L1
//   as beatSize-wide beats over valid/ready handshakes. A new line can be
//   accepted on the last beat of the current one, so lines stream without bubbles.
//   Optional feature macro: CRITICAL_WORD_FIRST_EN. When defined, each burst starts
//   at line_offset and wraps. When undefined, line_offset is ignored and every
//   burst runs 0..beats-1.
//   beats (lineSize/beatSize) must be a power of two and at least 2.
module line_beat_serializer #(
    parameter  int lineSize = 512,
    parameter  int beatSize = 64,
    localparam int beats    = lineSize / beatSize,
    localparam int idxBits  = $clog2(beats)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                line_valid,
    output logic                line_ready,
    input  logic [lineSize-1:0] line_in,
    input  logic [idxBits-1:0]  line_offset,
    output logic                beat_valid,
    input  logic                beat_ready,
    output logic [beatSize-1:0] beat_data,
    output logic [idxBits-1:0]  beat_index,
    output logic                beat_last,
    output logic                busy
);

    typedef enum logic {IDLE, SEND} state_t;

    state_t                         state;
    state_t                         state_nxt;
    logic [beats-1:0][beatSize-1:0] line_reg;
    logic [idxBits-1:0]             count;
    logic [idxBits-1:0]             start;
    logic                           ready_en;
    logic                           accept;
    logic                           xfer;

`ifdef CRITICAL_WORD_FIRST_EN
    assign start = line_offset;
`else
    logic unused_offset;
    assign start         = '0;
    assign unused_offset = ^line_offset;
`endif

    assign xfer       = beat_valid & beat_ready;
    assign line_ready = ready_en & ((state == IDLE) | ((state == SEND) & beat_last & beat_ready));
    assign accept     = line_valid & line_ready;
    assign beat_data  = line_reg[beat_index];

    // Keep line_ready low during reset and until the first clock after release.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: all clocked state uses non-blocking assignments so every register
        // samples the pre-edge values, independent of block ordering.
        if (!rst_n) ready_en <= 1'b0;
        else        ready_en <= 1'b1;
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next state: leave SEND only when the last beat goes out and no line replaces it.
    always_comb begin
        // NOTE: default first, so no path through the case leaves state_nxt unassigned (no latch).
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = SEND;
            SEND:    if (xfer && beat_last) state_nxt = accept ? SEND : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs derived from registered state only.
    always_comb begin
        busy       = (state == SEND);
        beat_valid = (state == SEND);
        beat_last  = (state == SEND) && (count == idxBits'(beats - 1));
    end

    // Line capture and beat sequencing; a capture overrides the final beat's advance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the line register is reset so beat_data reads zero out of reset
            // and a line interrupted by reset can never reappear.
            line_reg   <= '0;
            beat_index <= '0;
            count      <= '0;
        end else if (accept) begin
            line_reg   <= line_in;
            beat_index <= start;
            count      <= '0;
        end else if (xfer) begin
            beat_index <= beat_index + 1'b1;
            count      <= count + 1'b1;
        end
    end

endmodule

// File: tb/tb_line_beat_serializer.sv
// tb_line_beat_serializer
//   Directed stimulus with hand-computed expectations, plus a queue-based model:
//   every accepted line pushes its full beat sequence, every handshake pops one,
//   and a compare process checks the DUT against the queue head on each negedge.
module tb_line_beat_serializer;

    localparam int LS = 512;
    localparam int BS = 64;
    localparam int NB = 8;
    localparam int IB = 3;

    logic          clk         = 1'b0;
    logic          rst_n       = 1'b1;
    logic          line_valid  = 1'b0;
    logic          line_ready;
    logic [LS-1:0] line_in     = '0;
    logic [IB-1:0] line_offset = '0;
    logic          beat_valid;
    logic          beat_ready  = 1'b0;
    logic [BS-1:0] beat_data;
    logic [IB-1:0] beat_index;
    logic          beat_last;
    logic          busy;

    int passed = 0;
    int total  = 0;

    typedef struct {
        logic [BS-1:0] data;
        logic [IB-1:0] idx;
        logic          last;
    } beat_t;

    beat_t exp_q[$];
    bit    ready_en = 1'b0;

    line_beat_serializer #(.lineSize(LS), .beatSize(BS)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .line_valid (line_valid),
        .line_ready (line_ready),
        .line_in    (line_in),
        .line_offset(line_offset),
        .beat_valid (beat_valid),
        .beat_ready (beat_ready),
        .beat_data  (beat_data),
        .beat_index (beat_index),
        .beat_last  (beat_last),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got %h, expected %h", name, act, exp);
        else             passed++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [LS-1:0] make_line(input logic [63:0] base);
        logic [LS-1:0] l;
        for (int i = 0; i < NB; i++) l[i*BS +: BS] = base + 64'(i);
        return l;
    endfunction

    // A line is accepted when the model holds nothing, or only the final beat and it is taken now.
    function automatic bit model_ready();
        return ready_en && (exp_q.size() == 0 || (exp_q.size() == 1 && beat_ready === 1'b1));
    endfunction

    // Model update on each clock edge and on asynchronous reset.
    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            exp_q.delete();
            ready_en = 1'b0;
        end else begin
            bit    rdy;
            int    st;
            int    ix;
            beat_t b;
            rdy = model_ready();
            if (exp_q.size() > 0 && beat_ready === 1'b1) void'(exp_q.pop_front());
            if (line_valid === 1'b1 && rdy) begin
`ifdef CRITICAL_WORD_FIRST_EN
                st = int'(line_offset);
`else
                st = 0;
`endif
                for (int k = 0; k < NB; k++) begin
                    ix     = (st + k) % NB;
                    b.idx  = IB'(ix);
                    b.data = line_in[ix*BS +: BS];
                    b.last = (k == NB - 1);
                    exp_q.push_back(b);
                end
            end
            ready_en = 1'b1;
        end
    end

    // Compare DUT outputs against the model every negedge.
    initial forever begin
        @(negedge clk);
        if (!rst_n) begin
            check("rst beat_valid", 64'(beat_valid), 64'(0));
            check("rst line_ready", 64'(line_ready), 64'(0));
        end else begin
            check("cmp beat_valid", 64'(beat_valid), 64'(exp_q.size() > 0));
            check("cmp busy", 64'(busy), 64'(exp_q.size() > 0));
            check("cmp line_ready", 64'(line_ready), 64'(model_ready()));
            if (exp_q.size() > 0) begin
                check("cmp beat_data", beat_data, exp_q[0].data);
                check("cmp beat_index", 64'(beat_index), 64'(exp_q[0].idx));
                check("cmp beat_last", 64'(beat_last), 64'(exp_q[0].last));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    // Directed sequence.
    initial begin
        bit pat[6];
        int exp_idx[NB];
        int n;
        int k;
        logic [63:0] base;
        pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
`ifdef CRITICAL_WORD_FIRST_EN
        exp_idx = '{5, 6, 7, 0, 1, 2, 3, 4};
`else
        exp_idx = '{0, 1, 2, 3, 4, 5, 6, 7};
`endif

        // 1. Reset applied between clock edges.
        #1 rst_n = 1'b0;
        #2;
        check("reset beat_valid", 64'(beat_valid), 64'(0));
        check("reset busy", 64'(busy), 64'(0));
        check("reset beat_index", 64'(beat_index), 64'(0));
        check("reset beat_last", 64'(beat_last), 64'(0));
        check("reset beat_data", beat_data, 64'(0));
        check("reset line_ready", 64'(line_ready), 64'(0));
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        check("release line_ready before edge", 64'(line_ready), 64'(0));
        tick();
        check("release line_ready after edge", 64'(line_ready), 64'(1));

        // 2. Streaming, beat_ready always high.
        line_in = make_line(64'hA0); line_offset = '0; line_valid = 1'b1; beat_ready = 1'b1;
        tick();
        line_valid = 1'b0;
        for (int i = 0; i < NB; i++) begin
            check("stream data", beat_data, 64'hA0 + 64'(i));
            check("stream index", 64'(beat_index), 64'(i));
            check("stream last", 64'(beat_last), 64'(i == NB - 1));
            check("stream line_ready", 64'(line_ready), 64'(i == NB - 1));
            tick();
        end
        check("stream idle after line", 64'(beat_valid), 64'(0));

        // 3. Backpressure pattern 1,0,0,1,0,1 repeating.
        beat_ready = 1'b0; line_in = make_line(64'hC0); line_valid = 1'b1;
        tick();
        line_valid = 1'b0;
        n = 0; k = 0;
        while (n < NB && k < 64) begin
            beat_ready = pat[k % 6];
            if (beat_valid === 1'b1) begin
                check("bp data", beat_data, 64'hC0 + 64'(n));
                check("bp index", 64'(beat_index), 64'(n));
                if (beat_ready) n++;
            end
            tick();
            k++;
        end
        check("bp beats transferred", 64'(n), 64'(NB));
        check("bp idle after line", 64'(beat_valid), 64'(0));

        // 4. Back-to-back lines: B offered on A's last beat.
        beat_ready = 1'b1; line_in = make_line(64'h100); line_valid = 1'b1;
        tick();
        line_valid = 1'b0;
        for (int i = 0; i < 2 * NB; i++) begin
            base = (i < NB) ? 64'h100 : 64'h200;
            check("b2b valid", 64'(beat_valid), 64'(1));
            check("b2b index", 64'(beat_index), 64'(i % NB));
            check("b2b data", beat_data, base + 64'(i % NB));
            check("b2b last", 64'(beat_last), 64'((i % NB) == NB - 1));
            if (i == NB - 1) begin
                check("b2b line_ready on last", 64'(line_ready), 64'(1));
                line_in = make_line(64'h200); line_valid = 1'b1;
            end
            if (i == NB) line_valid = 1'b0;
            tick();
        end
        check("b2b idle after lines", 64'(beat_valid), 64'(0));

        // 5. Offset 5: wraps when the critical-word feature is built in, else ignored.
        line_in = make_line(64'h300); line_offset = 3'd5; line_valid = 1'b1;
        tick();
        line_valid = 1'b0; line_offset = '0;
        for (int i = 0; i < NB; i++) begin
            check("offset index", 64'(beat_index), 64'(exp_idx[i]));
            check("offset data", beat_data, 64'h300 + 64'(exp_idx[i]));
            check("offset last", 64'(beat_last), 64'(i == NB - 1));
            tick();
        end
        check("offset idle after line", 64'(beat_valid), 64'(0));

        // 6. Reset after three beats; the next line starts fresh.
        line_in = make_line(64'h400); line_valid = 1'b1;
        tick();
        line_valid = 1'b0;
        repeat (3) tick();
        check("midreset index before", 64'(beat_index), 64'(3));
        rst_n = 1'b0;
        #1;
        check("midreset beat_valid", 64'(beat_valid), 64'(0));
        check("midreset busy", 64'(busy), 64'(0));
        check("midreset beat_index", 64'(beat_index), 64'(0));
        check("midreset beat_last", 64'(beat_last), 64'(0));
        check("midreset beat_data", beat_data, 64'(0));
        check("midreset line_ready", 64'(line_ready), 64'(0));
        #1 rst_n = 1'b1;
        check("midreset line_ready before edge", 64'(line_ready), 64'(0));
        tick();
        check("midreset line_ready after edge", 64'(line_ready), 64'(1));
        line_in = make_line(64'h500); line_valid = 1'b1;
        tick();
        line_valid = 1'b0;
        for (int i = 0; i < NB; i++) begin
            check("post-reset index", 64'(beat_index), 64'(i));
            check("post-reset data", beat_data, 64'h500 + 64'(i));
            check("post-reset last", 64'(beat_last), 64'(i == NB - 1));
            tick();
        end
        check("post-reset idle", 64'(beat_valid), 64'(0));

        repeat (2) tick();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
